instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Inverse of the instruction decoder: packs register addresses, opcode and immediate fields into a 32-bit RV32I instruction word.
- Acts as the program loader. It accepts one field bundle per valid/ready handshake, encodes it and writes it into instruction memory at consecutive word addresses.
- Tracks the program length and flags illegal format requests.

Parameters:
- DEPTH, 64, instruction memory depth in words (power of two)
- AW, $clog2(DEPTH), write-address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear address/count, begin loading
- finish  in  1  one-cycle pulse: end loading
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- fmt  in  3  format: 0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- opcode  in  7  instr[6:0]
- rd  in  5  destination register address
- rs1  in  5  source register 1 address
- rs2  in  5  source register 2 address
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25] (R only)
- imm  in  32  immediate, pre-positioned (bit n = imm bit n)
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  AW  word address
- wr_data  out  32  encoded instruction
- count  out  AW+1  words written since start
- done  out  1  loading finished (finish seen or memory full)
- err  out  1  sticky: illegal fmt received since start

Behaviour:
- Reset: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, done=0, err=0. Reset mid-load abandons the load; no further write occurs.
- States:
  - IDLE: start -> LOAD.
  - LOAD: finish -> DONE; count reaching DEPTH -> DONE.
  - DONE: start -> LOAD.
- start in any state: wr_addr=0, count=0, err=0, done=0; next state LOAD. start wins over a same-cycle finish or in_valid; that bundle is dropped.
- in_ready = (state==LOAD) && (count<DEPTH), combinational from registered state only.
- Accept when in_valid && in_ready. A bundle accepted in cycle N produces wr_en=1 for exactly one cycle in N+1 with registered wr_addr/wr_data; one write per accept; back-to-back accepts give a continuous write stream.
- After each write, wr_addr increments (wraps to 0 only via start) and count increments.
- Encoding, other bits from fields; unused fields ignored:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Illegal fmt: handshake completes, no write, count unchanged, err=1 (sticky) from N+1.
- finish with a same-cycle accept: bundle is written in N+1, DONE entered N+1, done=1 from N+1.
- Full: the accept that makes count==DEPTH moves to DONE. in_ready=0 thereafter; in_valid is ignored without error.
- in_valid outside LOAD: ignored, no write.

Decomposition:
- Shared package (riscv_pkg): format enum (FMT_R..FMT_J), state enum, opcode constants (OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL).
- One sub-module, instr_pack: purely combinational fmt+fields -> {legal, word[31:0]}. Its round trip through the instruction decoder must be lossless.
- Top level holds the FSM, the address/count counters and the output registers.

Test Plan:
- Reset then start; R bundle opcode=0110011 rd=1 rs1=2 rs2=3 funct3=0 funct7=0 -> next cycle wr_en=1, wr_addr=0, wr_data=32'h003100B3, count=1.
- I bundle addi rd=5 rs1=0 imm=-1 (32'hFFFFFFFF), then S sw rs2=5 rs1=2 imm=8 funct3=2 back-to-back -> wr_data=32'hFFF00293 @0, 32'h00512423 @1, on consecutive cycles.
- B beq rs1=1 rs2=2 imm=-4 -> 32'hFE208EE3; J jal rd=1 imm=2048 -> 32'h001000EF. Decoder fields on wr_data match the inputs.
- DEPTH=4: hold in_valid for 6 bundles -> exactly 4 writes at addr 0..3, in_ready drops after 4th accept, done=1, count=4.
- fmt=7 mid-stream -> no write, err=1, count unchanged. start -> err=0, wr_addr=0.
- finish with a same-cycle accept -> that word is written, done=1. Reset asserted during LOAD -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoder types: formats, loader states, opcodes.
// Imported by the packer and the loader top level.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } st_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: format + fields -> instruction word.
// Formats 6 and 7 are reported illegal with a zero word.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    unique case (fmt)
      FMT_R: word = {funct7, rs2, rs1,
                     funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1,
                     funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1,
                     funct3, imm[4:0], opcode};
      // Branch offsets are even; imm[0] is dropped
      FMT_B: word = {imm[12], imm[10:5],
                     rs2, rs1, funct3,
                     imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1],
                     imm[11], imm[19:12],
                     rd, opcode};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: encodes one field bundle per handshake and
// writes it to instruction memory at consecutive word addresses.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    fmt,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic        legal;
  logic [31:0] word;

  instr_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .legal  (legal),
    .word   (word)
  );

  st_e           state_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;
  logic [AW:0]   count_q;
  logic          done_q;
  logic          err_q;

  logic accept;
  logic wr_ok;
  logic last;

  assign in_ready = (state_q == ST_LOAD)
                  && (count_q < FULL);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = accept && legal;
  assign last     = wr_ok
                  && (count_q == FULL - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'h0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (start) begin
        // A bundle offered with start is dropped
        state_q   <= ST_LOAD;
        wr_addr_q <= '0;
        count_q   <= '0;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        if (wr_ok) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= count_q[AW-1:0];
          wr_data_q <= word;
          count_q   <= count_q + 1'b1;
        end
        if (accept && !legal) begin
          err_q <= 1'b1;
        end
        if (state_q == ST_LOAD
            && (finish || last)) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for the instruction loader, DEPTH=4 so the
// full-memory path is reachable in a handful of cycles.
module tb_instruction_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          finish;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  instruction_encoder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .finish   (finish),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    fmt = f; opcode = op; rd = d;
    rs1 = s1; rs2 = s2; funct3 = f3;
    funct7 = f7; imm = im;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data,
         count, done, err} !== '0) begin
      bad++;
      $display("FAIL reset: rdy=%b en=%b a=%0d d=%h c=%0d dn=%b e=%b required all 0",
               in_ready, wr_en, wr_addr, wr_data,
               count, done, err);
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: got %b required 0", in_ready);
    end
  endtask

  task automatic test_rtype();
    do_start();
    total++;
    if (in_ready !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL start_load: rdy=%b c=%0d required 1 0",
               in_ready, count);
    end
    set_b(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3,
          3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd0
        || wr_data !== 32'h003100B3
        || count !== 3'd1) begin
      bad++;
      $display("FAIL rtype: en=%b a=%0d d=%h c=%0d required 1 0 003100b3 1",
               wr_en, wr_addr, wr_data, count);
    end
    tick();
    total++;
    if (wr_en !== 1'b0) begin
      bad++;
      $display("FAIL one_shot: en=%b required 0", wr_en);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    set_b(3'd1, 7'b0010011, 5'd5, 5'd0, 5'd0,
          3'd0, 7'd0, 32'hFFFFFFFF);
    in_valid = 1'b1;
    tick();
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd0
        || wr_data !== 32'hFFF00293) begin
      bad++;
      $display("FAIL itype: en=%b a=%0d d=%h required 1 0 fff00293",
               wr_en, wr_addr, wr_data);
    end
    set_b(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5,
          3'd2, 7'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd1
        || wr_data !== 32'h00512423
        || count !== 3'd2) begin
      bad++;
      $display("FAIL stype: en=%b a=%0d d=%h c=%0d required 1 1 00512423 2",
               wr_en, wr_addr, wr_data, count);
    end
  endtask

  task automatic test_branch_jump();
    logic [12:0] bimm;
    logic [20:0] jimm;
    do_start();
    set_b(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2,
          3'd0, 7'd0, 32'hFFFFFFFC);
    in_valid = 1'b1;
    tick();
    total++;
    if (wr_data !== 32'hFE208EE3) begin
      bad++;
      $display("FAIL btype: got %h required fe208ee3", wr_data);
    end
    bimm = {wr_data[31], wr_data[7],
            wr_data[30:25], wr_data[11:8], 1'b0};
    total++;
    if (bimm !== 13'h1FFC || wr_data[19:15] !== 5'd1
        || wr_data[24:20] !== 5'd2) begin
      bad++;
      $display("FAIL bdecode: imm=%h rs1=%0d rs2=%0d required 1ffc 1 2",
               bimm, wr_data[19:15], wr_data[24:20]);
    end
    set_b(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0,
          3'd0, 7'd0, 32'd2048);
    tick();
    total++;
    if (wr_data !== 32'h001000EF || wr_addr !== 2'd1) begin
      bad++;
      $display("FAIL jtype: d=%h a=%0d required 001000ef 1",
               wr_data, wr_addr);
    end
    jimm = {wr_data[31], wr_data[19:12],
            wr_data[20], wr_data[30:21], 1'b0};
    total++;
    if (jimm !== 21'd2048 || wr_data[11:7] !== 5'd1) begin
      bad++;
      $display("FAIL jdecode: imm=%0d rd=%0d required 2048 1",
               jimm, wr_data[11:7]);
    end
    set_b(3'd4, 7'b0110111, 5'd3, 5'd9, 5'd9,
          3'd7, 7'h7F, 32'h12345ABC);
    tick();
    in_valid = 1'b0;
    total++;
    if (wr_data !== 32'h123451B7 || count !== 3'd3) begin
      bad++;
      $display("FAIL utype: d=%h c=%0d required 123451b7 3",
               wr_data, count);
    end
  endtask

  task automatic test_full();
    int nw;
    logic early;
    nw = 0;
    early = 1'b0;
    do_start();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_b(3'd0, 7'b0110011, 5'(i + 1),
            5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
      tick();
      if (i == 2 && done !== 1'b0) early = 1'b1;
      if (wr_en === 1'b1) begin
        total++;
        if (wr_addr !== 2'(nw)
            || wr_data[11:7] !== 5'(nw + 1)) begin
          bad++;
          $display("FAIL full_addr: a=%0d rd=%0d required %0d %0d",
                   wr_addr, wr_data[11:7], nw, nw + 1);
        end
        nw++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (nw != 4 || early) begin
      bad++;
      $display("FAIL full_writes: got %0d early=%b required 4 0",
               nw, early);
    end
    total++;
    if (in_ready !== 1'b0 || done !== 1'b1
        || count !== 3'd4 || err !== 1'b0) begin
      bad++;
      $display("FAIL full_state: rdy=%b dn=%b c=%0d e=%b required 0 1 4 0",
               in_ready, done, count, err);
    end
  endtask

  task automatic test_illegal();
    do_start();
    set_b(3'd0, 7'b0110011, 5'd4, 5'd0, 5'd0,
          3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    tick();
    fmt = 3'd7;
    tick();
    total++;
    if (wr_en !== 1'b0 || err !== 1'b1
        || count !== 3'd1) begin
      bad++;
      $display("FAIL illegal: en=%b e=%b c=%0d required 0 1 1",
               wr_en, err, count);
    end
    fmt = 3'd6;
    tick();
    fmt = 3'd0;
    tick();
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd1
        || count !== 3'd2 || err !== 1'b1) begin
      bad++;
      $display("FAIL after_illegal: en=%b a=%0d c=%0d e=%b required 1 1 2 1",
               wr_en, wr_addr, count, err);
    end
    do_start();
    total++;
    if (err !== 1'b0 || wr_addr !== 2'd0
        || count !== 3'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart: e=%b a=%0d c=%0d dn=%b required 0 0 0 0",
               err, wr_addr, count, done);
    end
  endtask

  task automatic test_start_wins();
    set_b(3'd0, 7'b0110011, 5'd7, 5'd0, 5'd0,
          3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    tick();
    start = 1'b1;
    finish = 1'b1;
    tick();
    start = 1'b0;
    finish = 1'b0;
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b0 || count !== 3'd0
        || done !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_wins: en=%b c=%0d dn=%b rdy=%b required 0 0 0 1",
               wr_en, count, done, in_ready);
    end
  endtask

  task automatic test_finish();
    set_b(3'd1, 7'b0000011, 5'd6, 5'd2, 5'd0,
          3'd2, 7'd0, 32'd16);
    in_valid = 1'b1;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    total++;
    if (wr_en !== 1'b1 || done !== 1'b1
        || wr_data !== 32'h01012303
        || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL finish: en=%b dn=%b d=%h rdy=%b required 1 1 01012303 0",
               wr_en, done, wr_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b0 || count !== 3'd1
        || err !== 1'b0) begin
      bad++;
      $display("FAIL done_ignore: en=%b c=%0d e=%b required 0 1 0",
               wr_en, count, err);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    set_b(3'd0, 7'b0110011, 5'd1, 5'd1, 5'd1,
          3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    tick();
    fmt = 3'd7;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fmt = 3'd0;
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data,
         count, done, err} !== '0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%b en=%b a=%0d d=%h c=%0d dn=%b e=%b required all 0",
               in_ready, wr_en, wr_addr, wr_data,
               count, done, err);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL idle_ignore: en=%b c=%0d required 0 0",
               wr_en, count);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    finish = 1'b0;
    in_valid = 1'b0;
    set_b(3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
          3'd0, 7'd0, 32'h0);
    test_reset();
    test_rtype();
    test_back_to_back();
    test_branch_jump();
    test_full();
    test_illegal();
    test_start_wins();
    test_finish();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
